// File: rtl/segdisp_scheduler.sv
// segdisp_scheduler
//   Time-shares a 4-digit seven-segment display among NSRC 32-bit debug
//   sources.  Rotates round-robin over the enabled sources every DWELL cycles,
//   converts each value to sign + saturated 4-digit BCD with a sequential
//   double-dabble engine, and presents registered display words that only
//   change when a conversion completes.
//
// Ports
//   sys_clk     system clock
//   sys_rst_n   synchronous active-low reset
//   src_data    NSRC packed two's-complement sources, source i at [32i+31:32i]
//   src_valid   per-source display eligibility
//   hold        freezes the dwell timer
//   next_req    one-cycle pulse, advance to the next eligible source
//   disp_bcd    4 BCD digits, [15:12] = thousands
//   disp_neg    displayed value is negative
//   disp_ovf    magnitude exceeded 9999, digits saturated
//   disp_src    index of the displayed source
//   disp_valid  display outputs hold a converted value
//   busy        conversion in progress
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no eligible source, display cleared
// S_SELECT  | capture target source, sign/magnitude, load shifter
// S_CONVERT | 14 double-dabble iterations
// S_PRESENT | register converted value onto the display outputs
// S_DWELL   | display stable; watch for advance, drop-out or data change
module segdisp_scheduler #(
    parameter int NSRC  = 4,
    parameter int DWELL = 50000000,
    parameter int IW    = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NSRC*32-1:0]   src_data,
    input  logic [NSRC-1:0]      src_valid,
    input  logic                 hold,
    input  logic                 next_req,
    output logic [15:0]          disp_bcd,
    output logic                 disp_neg,
    output logic                 disp_ovf,
    output logic [IW-1:0]        disp_src,
    output logic                 disp_valid,
    output logic                 busy
);

    localparam int             CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]  DW_LOAD = CW'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_CONVERT, S_PRESENT, S_DWELL
    } state_t;

    state_t              state, next_state;
    logic [IW-1:0]       cur_idx, nxt_idx;
    logic [31:0]         sel_data, sel_mag, cap;
    logic                sel_ovf, cur_valid, any_valid;
    logic [CW-1:0]       dwell_cnt;
    logic                pending_adv, tc_hit, adv_now, take_adv, going_idle;
    logic [3:0]          conv_cnt;
    logic [29:0]         shifter, dd_adj;
    logic                val_neg, val_ovf;
    logic [2*NSRC-1:0]   dbl_valid;
    logic [NSRC-1:0]     rot_valid;
    int                  adv_off, idx_sum;

    assign any_valid = |src_valid;

    // Source mux and eligibility of the current index.
    always_comb begin
        sel_data  = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (cur_idx == IW'(i)) begin
                sel_data  = src_data[32*i +: 32];
                cur_valid = src_valid[i];
            end
        end
    end

    // Next eligible index after cur_idx, wrapping. Bit k of rot_valid is the
    // eligibility of index cur_idx+k+1 (mod NSRC); the lowest set bit wins.
    // With only the current source eligible this resolves back to cur_idx.
    always_comb begin
        dbl_valid = {src_valid, src_valid};
        rot_valid = NSRC'(dbl_valid >> (int'(cur_idx) + 1));
        adv_off   = 0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (rot_valid[k]) adv_off = k + 1;
        end
        idx_sum = int'(cur_idx) + adv_off;
        if (idx_sum >= NSRC) idx_sum = idx_sum - NSRC;
        nxt_idx = IW'(idx_sum);
    end

    // 0x80000000 negates to itself, which reads as 2^31 unsigned: saturates.
    assign sel_mag = sel_data[31] ? (~sel_data + 32'd1) : sel_data;
    assign sel_ovf = (sel_mag > 32'd9999);

    // Expiry and next_req in the same cycle fold into one advance.
    assign tc_hit     = (state != S_IDLE) && !hold && (dwell_cnt == '0);
    assign adv_now    = pending_adv || tc_hit || next_req;
    assign going_idle = (state == S_DWELL) && !any_valid;
    assign take_adv   = (state == S_DWELL) && any_valid && (adv_now || !cur_valid);

    // Double-dabble step: add 3 to every BCD nibble >= 5 before the shift.
    always_comb begin
        dd_adj = shifter;
        for (int n = 0; n < 4; n++) begin
            if (shifter[14+4*n +: 4] >= 4'd5)
                dd_adj[14+4*n +: 4] = shifter[14+4*n +: 4] + 4'd3;
        end
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (any_valid) next_state = S_SELECT;
            S_SELECT:  next_state = S_CONVERT;
            S_CONVERT: if (conv_cnt == 4'd0) next_state = S_PRESENT;
            S_PRESENT: next_state = S_DWELL;
            S_DWELL: begin
                if (!any_valid)             next_state = S_IDLE;
                else if (take_adv)          next_state = S_SELECT;
                else if (sel_data != cap)   next_state = S_SELECT;
            end
            default:   next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == S_SELECT) || (state == S_CONVERT);
    end

    // Source index, advance request and dwell timer. The timer is a down
    // counter reloaded with DWELL-1; a refresh does not reload it so the
    // rotation grid is kept.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cur_idx     <= IW'(NSRC - 1);
            pending_adv <= 1'b0;
            dwell_cnt   <= DW_LOAD;
        end else begin
            if ((state == S_IDLE && any_valid) || take_adv)
                cur_idx <= nxt_idx;

            if (state == S_IDLE || take_adv || going_idle)
                pending_adv <= 1'b0;
            else if (tc_hit || next_req)
                pending_adv <= 1'b1;

            if (state == S_IDLE || take_adv || going_idle)
                dwell_cnt <= DW_LOAD;
            else if (!hold)
                dwell_cnt <= (dwell_cnt == '0) ? DW_LOAD : dwell_cnt - 1'b1;
        end
    end

    // Capture and conversion datapath
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cap      <= '0;
            val_neg  <= 1'b0;
            val_ovf  <= 1'b0;
            shifter  <= '0;
            conv_cnt <= '0;
        end else begin
            case (state)
                S_SELECT: begin
                    cap      <= sel_data;
                    val_neg  <= sel_data[31];
                    val_ovf  <= sel_ovf;
                    shifter  <= {16'd0, sel_ovf ? 14'd9999 : sel_mag[13:0]};
                    conv_cnt <= 4'd13;
                end
                S_CONVERT: begin
                    shifter  <= {dd_adj[28:0], 1'b0};
                    conv_cnt <= conv_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Display registers: loaded only in PRESENT, cleared on the edge that
    // enters IDLE so the drop-out is visible one cycle after it is seen.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            disp_bcd   <= '0;
            disp_neg   <= 1'b0;
            disp_ovf   <= 1'b0;
            disp_src   <= '0;
            disp_valid <= 1'b0;
        end else if (state == S_PRESENT) begin
            disp_bcd   <= shifter[29:14];
            disp_neg   <= val_neg;
            disp_ovf   <= val_ovf;
            disp_src   <= cur_idx;
            disp_valid <= 1'b1;
        end else if (state == S_IDLE || going_idle) begin
            disp_bcd   <= '0;
            disp_neg   <= 1'b0;
            disp_ovf   <= 1'b0;
            disp_src   <= '0;
            disp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_segdisp_scheduler.sv
// Testbench for segdisp_scheduler: scoreboard of expected display words,
// pushed when stimulus is driven and popped when the display changes.
module tb_segdisp_scheduler;

    localparam int NSRC  = 4;
    localparam int DWELL = 32;
    localparam int IW    = 3;

    logic                sys_clk   = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic [NSRC*32-1:0]  src_data  = '0;
    logic [NSRC-1:0]     src_valid = '0;
    logic                hold      = 1'b0;
    logic                next_req  = 1'b0;
    logic [15:0]         disp_bcd;
    logic                disp_neg;
    logic                disp_ovf;
    logic [IW-1:0]       disp_src;
    logic                disp_valid;
    logic                busy;

    typedef struct packed {
        logic [IW-1:0] src;
        logic          ovf;
        logic          neg;
        logic [15:0]   bcd;
    } disp_t;

    disp_t exp_q[$];
    int    upd_times[$];
    int    upd_count = 0;
    int    seen      = 0;
    int    cyc       = 0;
    int    n_checks  = 0;
    int    n_fail    = 0;

    logic [31:0] sweep [7] = '{32'hFFFF_FFD6, 32'hFFFF_D8F1, 32'd9999, 32'd10000,
                               32'd0, 32'd12345, 32'h8000_0000};

    segdisp_scheduler #(.NSRC(NSRC), .DWELL(DWELL), .IW(IW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .hold       (hold),
        .next_req   (next_req),
        .disp_bcd   (disp_bcd),
        .disp_neg   (disp_neg),
        .disp_ovf   (disp_ovf),
        .disp_src   (disp_src),
        .disp_valid (disp_valid),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: sign/magnitude, saturate to 9999, decimal digits by division.
    function automatic disp_t model(input int idx, input logic [31:0] v);
        logic [31:0] mag;
        int          m;
        disp_t       d;
        d.neg = v[31];
        mag   = v[31] ? (32'd0 - v) : v;
        d.ovf = (mag > 32'd9999);
        m     = d.ovf ? 9999 : int'(mag);
        d.bcd = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
        d.src = IW'(idx);
        return d;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [31:0] v);
        src_data[idx*32 +: 32] = v;
    endtask

    task automatic push_exp(input int idx);
        exp_q.push_back(model(idx, src_data[idx*32 +: 32]));
    endtask

    task automatic wait_update(input string tag, input int lim, output int t);
        int k;
        k = 0;
        while (upd_count <= seen && k < lim) begin
            tick();
            k++;
        end
        if (upd_count > seen) begin
            t = upd_times[seen];
            seen++;
        end else begin
            chk_eq({tag, "_timeout"}, upd_count, seen + 1);
            t = -1000;
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk_eq({tag, "_bcd"},   disp_bcd,   0);
        chk_eq({tag, "_neg"},   disp_neg,   0);
        chk_eq({tag, "_ovf"},   disp_ovf,   0);
        chk_eq({tag, "_src"},   disp_src,   0);
        chk_eq({tag, "_valid"}, disp_valid, 0);
        chk_eq({tag, "_busy"},  busy,       0);
    endtask

    // Display monitor: each visible change of a valid display is one update.
    initial begin
        disp_t           o;
        logic [IW+18:0]  prev, curv;
        prev = '0;
        forever begin
            @(negedge sys_clk);
            curv = {disp_valid, disp_src, disp_ovf, disp_neg, disp_bcd};
            if (disp_valid === 1'b1 && curv !== prev) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_update", 32'(exp_q.size()), 1);
                end else begin
                    o = exp_q.pop_front();
                    chk_eq("disp_bcd", disp_bcd, o.bcd);
                    chk_eq("disp_neg", disp_neg, o.neg);
                    chk_eq("disp_ovf", disp_ovf, o.ovf);
                    chk_eq("disp_src", disp_src, o.src);
                end
                upd_times.push_back(cyc);
                upd_count++;
            end
            prev = curv;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0, t1, t2, t3, c0, r, base, k;

        // Reset state
        repeat (3) tick();
        chk_cleared("reset");

        // Basic conversion and first-display latency
        set_src(0, 32'd1234);
        src_valid = 4'b0001;
        sys_rst_n = 1'b1;
        c0 = cyc;
        push_exp(0);
        wait_update("basic", 40, t);
        chk_eq("basic_latency", t - c0, 17);

        // Negative, saturation and boundary values via refresh of source 0
        foreach (sweep[i]) begin
            set_src(0, sweep[i]);
            push_exp(0);
            wait_update("sweep", 60, t);
        end

        // Rotation over 1011
        sys_rst_n = 1'b0;
        tick();
        tick();
        set_src(0, 32'd100);
        set_src(1, 32'hFFFF_FF38);
        set_src(2, 32'd777);
        set_src(3, 32'd3000);
        src_valid = 4'b1011;
        sys_rst_n = 1'b1;
        c0 = cyc;
        push_exp(0);
        push_exp(1);
        push_exp(3);
        push_exp(0);
        wait_update("rot0", 40, t0);
        wait_update("rot1", 60, t1);
        wait_update("rot2", 60, t2);
        wait_update("rot3", 60, t3);
        chk_eq("rot_latency", t0 - c0, 17);
        chk_eq("rot_gap01", t1 - t0, DWELL);
        chk_eq("rot_gap13", t2 - t1, DWELL);
        chk_eq("rot_gap30", t3 - t2, DWELL);

        // Hold freezes rotation; next_req still advances
        hold = 1'b1;
        base = upd_count;
        repeat (100) tick();
        chk_eq("hold_updates", upd_count, base);
        chk_eq("hold_src", disp_src, 0);
        next_req = 1'b1;
        c0 = cyc;
        push_exp(1);
        tick();
        next_req = 1'b0;
        wait_update("next_req", 40, t);
        chk_eq("next_req_latency", t - c0, 17);
        base = upd_count;
        repeat (60) tick();
        chk_eq("hold_after_req", upd_count, base);
        hold = 1'b0;

        // Refresh mid-dwell: same index, timer not reloaded, so the expiry
        // during the refresh conversion advances on the first DWELL cycle.
        sys_rst_n = 1'b0;
        tick();
        tick();
        set_src(0, 32'd5);
        set_src(3, 32'd50);
        src_valid = 4'b1001;
        sys_rst_n = 1'b1;
        c0 = cyc;
        push_exp(0);
        wait_update("refresh_first", 40, t0);
        chk_eq("refresh_first_latency", t0 - c0, 17);
        k = 0;
        while (cyc < t0 + 5 && k < 20) begin
            tick();
            k++;
        end
        r = cyc;
        set_src(0, 32'd6);
        push_exp(0);
        push_exp(3);
        wait_update("refresh", 40, t1);
        wait_update("refresh_rot", 40, t2);
        chk_eq("refresh_latency", t1 - r, 17);
        chk_eq("refresh_rot_gap", t2 - t1, 17);

        // Drop-out to IDLE clears outputs on the next edge
        src_valid = 4'b0000;
        tick();
        chk_eq("dropout_valid", disp_valid, 0);
        chk_eq("dropout_bcd", disp_bcd, 0);
        chk_eq("dropout_src", disp_src, 0);
        repeat (20) tick();
        chk_eq("idle_valid", disp_valid, 0);
        chk_eq("idle_busy", busy, 0);

        // 1010 from IDLE (current 3): 1, 3, then abort conversion of 1
        set_src(1, 32'd321);
        set_src(3, 32'hFFFF_FFFB);
        src_valid = 4'b1010;
        push_exp(1);
        push_exp(3);
        wait_update("abort_pre1", 40, t);
        wait_update("abort_pre3", 60, t);
        k = 0;
        while (busy !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        repeat (5) tick();
        chk_eq("abort_busy", busy, 1);
        sys_rst_n = 1'b0;
        tick();
        chk_cleared("abort_reset");
        sys_rst_n = 1'b1;
        c0 = cyc;
        push_exp(1);
        wait_update("restart", 40, t);
        chk_eq("restart_latency", t - c0, 17);

        repeat (3) tick();
        chk_eq("sb_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
